// File: rtl/armleocpu_cache_arbiter.sv
// Shares one cache port between instruction fetch (f_*) and load/store (d_*) requesters.
// Define ARMLEOCPU_CACHE_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise FIXED_PRIORITY wins ties.
module armleocpu_cache_arbiter #(
  parameter int FIXED_PRIORITY = 1,
  parameter int MAX_BURST      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_reset_done,
  input  logic [3:0]  c_response,
  input  logic [31:0] c_load_data,
  output logic [3:0]  c_cmd,
  output logic [31:0] c_address,
  output logic [2:0]  c_load_type,
  output logic [1:0]  c_store_type,
  output logic [31:0] c_store_data,
  input  logic [3:0]  f_cmd,
  input  logic [31:0] f_address,
  output logic [3:0]  f_response,
  output logic [31:0] f_load_data,
  output logic        f_reset_done,
  input  logic [3:0]  d_cmd,
  input  logic [31:0] d_address,
  input  logic [2:0]  d_load_type,
  input  logic [1:0]  d_store_type,
  input  logic [31:0] d_store_data,
  output logic [3:0]  d_response,
  output logic [31:0] d_load_data,
  output logic        d_reset_done,
  output logic [1:0]  arb_owner
);

  localparam logic [3:0] CMD_NONE         = 4'd0;
  localparam logic [3:0] RESP_IDLE        = 4'd0;
  localparam logic [3:0] RESP_WAIT        = 4'd1;
  localparam logic [3:0] RESP_DONE        = 4'd2;
  localparam logic [3:0] RESP_ACCESSFAULT = 4'd3;
  localparam logic [3:0] RESP_PAGEFAULT   = 4'd4;
  localparam logic [3:0] RESP_MISSALIGNED = 4'd5;
  localparam logic [2:0] LD_TYPE_LW       = 3'b010;
  localparam logic       FIXED_D          = (FIXED_PRIORITY != 0);
  localparam logic [3:0] MAX_BURST_L      = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_F = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;

  logic f_pend, d_pend, both_pend, busy, owner_d, completion, locked, arb_cycle, active;
  logic tie_d, starve, grant_valid, grant_d, sel_valid, sel_d;

  assign f_pend     = (f_cmd != CMD_NONE);
  assign d_pend     = (d_cmd != CMD_NONE);
  assign both_pend  = f_pend && d_pend;
  assign busy       = (state_q != ST_IDLE);
  assign owner_d    = (state_q == ST_BUSY_D);
  assign completion = (c_response == RESP_DONE) || (c_response == RESP_ACCESSFAULT) ||
                      (c_response == RESP_MISSALIGNED) || (c_response == RESP_PAGEFAULT);
  assign locked     = busy && (c_response == RESP_WAIT);
  assign arb_cycle  = !busy || completion;
  assign active     = !rst && c_reset_done;

`ifdef ARMLEOCPU_CACHE_ARB_ROUND_ROBIN_EN
  assign tie_d = !last_grant_q;
`else
  assign tie_d = FIXED_D;
`endif

  // Starvation only matters back-to-back: from IDLE the other side was not waiting on us.
  assign starve      = busy && both_pend && (burst_cnt_q >= MAX_BURST_L);
  assign grant_valid = f_pend || d_pend;
  assign grant_d     = both_pend ? (starve ? !owner_d : tie_d) : d_pend;

  always_comb begin
    sel_valid = 1'b0;
    sel_d     = 1'b0;
    if (active) begin
      if (locked) begin
        sel_valid = 1'b1;
        sel_d     = owner_d;
      end else if (arb_cycle) begin
        sel_valid = grant_valid;
        sel_d     = grant_d;
      end
    end
    c_cmd        = CMD_NONE;
    c_address    = d_address;
    c_load_type  = d_load_type;
    c_store_type = d_store_type;
    c_store_data = d_store_data;
    if (sel_valid) begin
      if (sel_d) begin
        c_cmd = d_cmd;
      end else begin
        c_cmd        = f_cmd;
        c_address    = f_address;
        c_load_type  = LD_TYPE_LW;
        c_store_type = 2'd0;
        c_store_data = 32'd0;
      end
    end
  end

  always_comb begin
    f_response = RESP_IDLE;
    d_response = RESP_IDLE;
    if (active) begin
      f_response = f_pend ? RESP_WAIT : RESP_IDLE;
      d_response = d_pend ? RESP_WAIT : RESP_IDLE;
      if (locked || (busy && completion)) begin
        if (owner_d) d_response = c_response;
        else         f_response = c_response;
      end
    end
  end

  assign f_load_data  = c_load_data;
  assign d_load_data  = c_load_data;
  assign f_reset_done = c_reset_done;
  assign d_reset_done = c_reset_done;
  assign arb_owner    = state_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    if (!c_reset_done) begin
      state_d = ST_IDLE;
    end else if (locked) begin
      state_d = state_q;
    end else if (arb_cycle) begin
      if (grant_valid) begin
        state_d      = grant_d ? ST_BUSY_D : ST_BUSY_F;
        last_grant_d = grant_d;
        if (busy && (grant_d == owner_d) && (grant_d ? f_pend : d_pend))
          burst_cnt_d = (burst_cnt_q == 4'hF) ? 4'hF : burst_cnt_q + 4'd1;
        else
          burst_cnt_d = 4'd1;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      // Cache answered something other than WAIT or a completion: drop the command.
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= FIXED_D;
      burst_cnt_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

`ifndef SYNTHESIS
  a_cache_protocol: assert property (@(posedge clk) disable iff (rst)
    (c_reset_done && busy) |-> (locked || completion));
`endif

endmodule
